// File: rtl/id_reg_stage.sv
// Decode/register-read stage with valid/ready bundle toward EX.
// Define ID_FWD_EN for EX/MEM forwarding; otherwise any pending writer stalls.
module id_reg_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_valid_i,
  input  logic [31:0]           inst_i,
  input  logic [DATA_W-1:0]     pc_i,
  output logic                  inst_ready_o,
  output logic                  reg1_read_o,
  output logic                  reg2_read_o,
  output logic [REG_ADDR_W-1:0] reg1_addr_o,
  output logic [REG_ADDR_W-1:0] reg2_addr_o,
  input  logic [DATA_W-1:0]     reg1_data_i,
  input  logic [DATA_W-1:0]     reg2_data_i,
  input  logic                  ex_wreg_i,
  input  logic [REG_ADDR_W-1:0] ex_wd_i,
  input  logic [DATA_W-1:0]     ex_wdata_i,
  input  logic                  ex_is_load_i,
  input  logic                  mem_wreg_i,
  input  logic [REG_ADDR_W-1:0] mem_wd_i,
  input  logic [DATA_W-1:0]     mem_wdata_i,
  input  logic                  flush_i,
  output logic                  ex_valid_o,
  input  logic                  ex_ready_i,
  output logic [7:0]            aluop_o,
  output logic [2:0]            alusel_o,
  output logic [DATA_W-1:0]     reg1_o,
  output logic [DATA_W-1:0]     reg2_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [DATA_W-1:0]     pc_o,
  output logic                  inst_invalid_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [7:0] EXE_ANDI_OP = 8'b0101_1001;
  localparam logic [7:0] EXE_ORI_OP  = 8'b0101_1010;
  localparam logic [7:0] EXE_XORI_OP = 8'b0101_1011;
  localparam logic [7:0] EXE_LUI_OP  = 8'b0101_1100;
  localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

  logic [5:0]            w_op;
  logic [5:0]            w_fn;
  logic [REG_ADDR_W-1:0] w_rs;
  logic [REG_ADDR_W-1:0] w_rt;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [DATA_W-1:0]     w_zimm;
  logic [DATA_W-1:0]     w_limm;
  logic [DATA_W-1:0]     w_sa;

  assign w_op   = inst_i[31:26];
  assign w_fn   = inst_i[5:0];
  assign w_rs   = REG_ADDR_W'(inst_i[25:21]);
  assign w_rt   = REG_ADDR_W'(inst_i[20:16]);
  assign w_rd   = REG_ADDR_W'(inst_i[15:11]);
  assign w_zimm = DATA_W'(inst_i[15:0]);
  assign w_limm = DATA_W'({inst_i[15:0], 16'h0000});
  assign w_sa   = DATA_W'(inst_i[10:6]);

  logic w_sp;
  logic w_and, w_or, w_xor, w_nor;
  logic w_sll, w_srl, w_sra;
  logic w_andi, w_ori, w_xori, w_lui;

  assign w_sp   = (w_op == 6'b000000);
  assign w_and  = w_sp && (w_fn == 6'b100100);
  assign w_or   = w_sp && (w_fn == 6'b100101);
  assign w_xor  = w_sp && (w_fn == 6'b100110);
  assign w_nor  = w_sp && (w_fn == 6'b100111);
  assign w_sll  = w_sp && (w_fn == 6'b000000);
  assign w_srl  = w_sp && (w_fn == 6'b000010);
  assign w_sra  = w_sp && (w_fn == 6'b000011);
  assign w_andi = (w_op == 6'b001100);
  assign w_ori  = (w_op == 6'b001101);
  assign w_xori = (w_op == 6'b001110);
  assign w_lui  = (w_op == 6'b001111);

  logic [7:0]            w_aluop;
  logic [2:0]            w_alusel;
  logic                  w_wreg;
  logic                  w_inv;
  logic                  w_r1_rd;
  logic                  w_r2_rd;
  logic [DATA_W-1:0]     w_imm;
  logic [REG_ADDR_W-1:0] w_wd;

  always_comb begin
    w_aluop  = EXE_NOP_OP;
    w_alusel = EXE_RES_NOP;
    w_wreg   = 1'b0;
    w_inv    = 1'b1;
    w_r1_rd  = 1'b0;
    w_r2_rd  = 1'b0;
    w_imm    = '0;
    w_wd     = w_rd;
    unique case (1'b1)
      w_andi, w_ori, w_xori, w_lui: begin
        w_alusel = EXE_RES_LOGIC;
        w_wreg   = 1'b1;
        w_inv    = 1'b0;
        w_r1_rd  = 1'b1;
        w_wd     = w_rt;
        w_imm    = w_lui ? w_limm : w_zimm;
        w_aluop  = w_andi ? EXE_ANDI_OP :
                   w_ori  ? EXE_ORI_OP  :
                   w_xori ? EXE_XORI_OP :
                            EXE_LUI_OP;
      end
      w_and, w_or, w_xor, w_nor: begin
        w_alusel = EXE_RES_LOGIC;
        w_wreg   = 1'b1;
        w_inv    = 1'b0;
        w_r1_rd  = 1'b1;
        w_r2_rd  = 1'b1;
        w_aluop  = w_and ? EXE_AND_OP :
                   w_or  ? EXE_OR_OP  :
                   w_xor ? EXE_XOR_OP :
                           EXE_NOR_OP;
      end
      w_sll, w_srl, w_sra: begin
        w_alusel = EXE_RES_SHIFT;
        w_wreg   = 1'b1;
        w_inv    = 1'b0;
        w_r2_rd  = 1'b1;
        w_imm    = w_sa;
        w_aluop  = w_sll ? EXE_SLL_OP :
                   w_srl ? EXE_SRL_OP :
                           EXE_SRA_OP;
      end
      default: ;
    endcase
  end

  assign reg1_read_o = w_r1_rd;
  assign reg2_read_o = w_r2_rd;
  assign reg1_addr_o = w_rs;
  assign reg2_addr_o = w_rt;

  // A source matches a writer only when actually read and nonzero.
  logic w_ex1, w_ex2, w_mem1, w_mem2;
  logic w_hazard;

  assign w_ex1  = w_r1_rd && (w_rs != '0) &&
                  ex_wreg_i && (ex_wd_i == w_rs);
  assign w_ex2  = w_r2_rd && (w_rt != '0) &&
                  ex_wreg_i && (ex_wd_i == w_rt);
  assign w_mem1 = w_r1_rd && (w_rs != '0) &&
                  mem_wreg_i && (mem_wd_i == w_rs);
  assign w_mem2 = w_r2_rd && (w_rt != '0) &&
                  mem_wreg_i && (mem_wd_i == w_rt);

`ifdef ID_FWD_EN
  assign w_hazard = ex_is_load_i && (w_ex1 || w_ex2);
`else
  logic w_unused;
  assign w_hazard = w_ex1 || w_ex2 || w_mem1 || w_mem2;
  assign w_unused = ^{ex_wdata_i, mem_wdata_i, ex_is_load_i};
`endif

  logic [DATA_W-1:0] w_reg1;
  logic [DATA_W-1:0] w_reg2;

  always_comb begin
    w_reg1 = reg1_data_i;
    if (!w_r1_rd)
      w_reg1 = w_imm;
    else if (w_rs == '0)
      w_reg1 = '0;
`ifdef ID_FWD_EN
    else if (w_ex1)
      w_reg1 = ex_wdata_i;
    else if (w_mem1)
      w_reg1 = mem_wdata_i;
`endif
  end

  always_comb begin
    w_reg2 = reg2_data_i;
    if (!w_r2_rd)
      w_reg2 = w_imm;
    else if (w_rt == '0)
      w_reg2 = '0;
`ifdef ID_FWD_EN
    else if (w_ex2)
      w_reg2 = ex_wdata_i;
    else if (w_mem2)
      w_reg2 = mem_wdata_i;
`endif
  end

  logic                  r_valid;
  logic [7:0]            r_aluop;
  logic [2:0]            r_alusel;
  logic [DATA_W-1:0]     r_reg1;
  logic [DATA_W-1:0]     r_reg2;
  logic [REG_ADDR_W-1:0] r_wd;
  logic                  r_wreg;
  logic [DATA_W-1:0]     r_pc;
  logic                  r_inv;
  logic [CNT_W-1:0]      r_stall;
  logic                  w_accept;

  assign inst_ready_o = !rst && !flush_i && !w_hazard &&
                        (!r_valid || ex_ready_i);
  assign w_accept     = inst_valid_i && inst_ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_aluop  <= EXE_NOP_OP;
      r_alusel <= EXE_RES_NOP;
      r_reg1   <= '0;
      r_reg2   <= '0;
      r_wd     <= '0;
      r_wreg   <= 1'b0;
      r_pc     <= '0;
      r_inv    <= 1'b0;
    end else if (flush_i) begin
      r_valid  <= 1'b0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_aluop  <= w_aluop;
      r_alusel <= w_alusel;
      r_reg1   <= w_reg1;
      r_reg2   <= w_reg2;
      r_wd     <= w_wd;
      r_wreg   <= w_wreg;
      r_pc     <= pc_i;
      r_inv    <= w_inv;
    end else if (ex_ready_i) begin
      r_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall <= '0;
    else if (inst_valid_i && w_hazard && !flush_i &&
             (r_stall != '1))
      r_stall <= r_stall + CNT_W'(1);
  end

  assign ex_valid_o     = r_valid;
  assign aluop_o        = r_aluop;
  assign alusel_o       = r_alusel;
  assign reg1_o         = r_reg1;
  assign reg2_o         = r_reg2;
  assign wd_o           = r_wd;
  assign wreg_o         = r_wreg;
  assign pc_o           = r_pc;
  assign inst_invalid_o = r_inv;
  assign stall_cnt_o    = r_stall;

endmodule

// File: tb/tb_id_reg_stage.sv
// Scoreboard bench for id_reg_stage: directed cases, then random traffic
// against an instruction-level reference model.
module tb_id_reg_stage;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 16;

  localparam logic [7:0] NOP  = 8'h00;
  localparam logic [7:0] AND_ = 8'h24;
  localparam logic [7:0] OR_  = 8'h25;
  localparam logic [7:0] XOR_ = 8'h26;
  localparam logic [7:0] NOR_ = 8'h27;
  localparam logic [7:0] ANDI = 8'h59;
  localparam logic [7:0] ORI  = 8'h5a;
  localparam logic [7:0] XORI = 8'h5b;
  localparam logic [7:0] LUI  = 8'h5c;
  localparam logic [7:0] SLL  = 8'h7c;
  localparam logic [7:0] SRL  = 8'h02;
  localparam logic [7:0] SRA  = 8'h03;

  logic clk = 1'b0;
  logic rst;
  logic inst_valid_i, inst_ready_o;
  logic [31:0] inst_i;
  logic [DW-1:0] pc_i;
  logic reg1_read_o, reg2_read_o;
  logic [AW-1:0] reg1_addr_o, reg2_addr_o;
  logic [DW-1:0] reg1_data_i, reg2_data_i;
  logic ex_wreg_i, ex_is_load_i, mem_wreg_i;
  logic [AW-1:0] ex_wd_i, mem_wd_i;
  logic [DW-1:0] ex_wdata_i, mem_wdata_i;
  logic flush_i, ex_valid_o, ex_ready_i;
  logic [7:0] aluop_o;
  logic [2:0] alusel_o;
  logic [DW-1:0] reg1_o, reg2_o, pc_o;
  logic [AW-1:0] wd_o;
  logic wreg_o, inst_invalid_o;
  logic [CW-1:0] stall_cnt_o;

  logic [DW-1:0] regs [32];
  assign reg1_data_i = regs[reg1_addr_o];
  assign reg2_data_i = regs[reg2_addr_o];

  always #5 clk = ~clk;

  id_reg_stage dut (
    .clk(clk), .rst(rst),
    .inst_valid_i(inst_valid_i), .inst_i(inst_i),
    .pc_i(pc_i), .inst_ready_o(inst_ready_o),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i),
    .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i),
    .mem_wdata_i(mem_wdata_i), .flush_i(flush_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .aluop_o(aluop_o), .alusel_o(alusel_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o),
    .wreg_o(wreg_o), .pc_o(pc_o),
    .inst_invalid_o(inst_invalid_o),
    .stall_cnt_o(stall_cnt_o)
  );

  typedef struct packed {
    logic [7:0]    aluop;
    logic [2:0]    alusel;
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic [AW-1:0] wd;
    logic          wreg;
    logic [DW-1:0] pc;
    logic          inv;
  } bund_t;

  bund_t q[$];
  bund_t mon_a;
  int n_chk = 0;
  int n_err = 0;
  bit m_valid;
  int m_stall;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
`ifdef ID_FWD_EN
    return ex_is_load_i && ex_wreg_i && (ex_wd_i == a);
`else
    return (ex_wreg_i && (ex_wd_i == a)) ||
           (mem_wreg_i && (mem_wd_i == a));
`endif
  endfunction

  function automatic logic [DW-1:0] opv(input logic [4:0] a);
    if (a == 5'd0) return '0;
`ifdef ID_FWD_EN
    if (ex_wreg_i && (ex_wd_i == a)) return ex_wdata_i;
    if (mem_wreg_i && (mem_wd_i == a)) return mem_wdata_i;
`endif
    return regs[a];
  endfunction

  function automatic bund_t model(input logic [31:0] ins,
                                  input logic [DW-1:0] pc,
                                  output bit hz);
    bund_t b;
    bit u1, u2;
    logic [DW-1:0] imm;
    logic [5:0] op, fn;
    logic [4:0] rs, rt;
    op = ins[31:26];
    fn = ins[5:0];
    rs = ins[25:21];
    rt = ins[20:16];
    b = '0;
    b.pc = pc;
    b.wd = ins[15:11];
    u1 = 1'b0;
    u2 = 1'b0;
    imm = '0;
    if (op inside {6'h0c, 6'h0d, 6'h0e, 6'h0f}) begin
      u1 = 1'b1;
      b.wd = rt;
      b.wreg = 1'b1;
      b.alusel = 3'd1;
      imm = (op == 6'h0f) ? {ins[15:0], 16'h0} : {16'h0, ins[15:0]};
      b.aluop = (op == 6'h0c) ? ANDI : (op == 6'h0d) ? ORI :
                (op == 6'h0e) ? XORI : LUI;
    end else if (op == 6'h00 && fn inside {6'h24, 6'h25, 6'h26, 6'h27}) begin
      u1 = 1'b1;
      u2 = 1'b1;
      b.wreg = 1'b1;
      b.alusel = 3'd1;
      b.aluop = (fn == 6'h24) ? AND_ : (fn == 6'h25) ? OR_ :
                (fn == 6'h26) ? XOR_ : NOR_;
    end else if (op == 6'h00 && fn inside {6'h00, 6'h02, 6'h03}) begin
      u2 = 1'b1;
      b.wreg = 1'b1;
      b.alusel = 3'd2;
      imm = {27'h0, ins[10:6]};
      b.aluop = (fn == 6'h00) ? SLL : (fn == 6'h02) ? SRL : SRA;
    end else begin
      b.inv = 1'b1;
    end
    b.r1 = u1 ? opv(rs) : imm;
    b.r2 = u2 ? opv(rt) : imm;
    hz = (u1 && busy(rs)) || (u2 && busy(rt));
    return b;
  endfunction

  function automatic logic [31:0] gen();
    int k;
    logic [4:0] rs, rt, rd, sa;
    logic [15:0] imm;
    logic [5:0] fn;
    k = $urandom_range(0, 11);
    rs = 5'($urandom_range(0, 4));
    rt = 5'($urandom_range(0, 4));
    rd = 5'($urandom_range(0, 4));
    sa = 5'($urandom);
    imm = 16'($urandom);
    case (k)
      0: return {6'h0c, rs, rt, imm};
      1: return {6'h0d, rs, rt, imm};
      2: return {6'h0e, rs, rt, imm};
      3: return {6'h0f, 5'd0, rt, imm};
      4, 5, 6, 7: begin
        fn = 6'h24 + 6'(k - 4);
        return {6'h00, rs, rt, rd, 5'd0, fn};
      end
      8: return {6'h00, 5'd0, rt, rd, sa, 6'h00};
      9: return {6'h00, 5'd0, rt, rd, sa, 6'h02};
      10: return {6'h00, 5'd0, rt, rd, sa, 6'h03};
      default: begin
        if ($urandom_range(0, 1) == 0)
          return {6'h3f, 26'($urandom)};
        return {6'h00, rs, rt, rd, sa, 6'h3f};
      end
    endcase
  endfunction

  // Inputs are applied just after a rising edge; tick() checks the
  // combinational side at the falling edge and advances the model.
  task automatic tick();
    bit hz, rdy;
    bund_t e;
    e = model(inst_i, pc_i, hz);
    rdy = !flush_i && !hz && (!m_valid || ex_ready_i);
    @(negedge clk);
    chk("inst_ready_o", 64'(inst_ready_o), 64'(rdy));
    chk("ex_valid_o", 64'(ex_valid_o), 64'(m_valid));
    chk("stall_cnt_o", 64'(stall_cnt_o), 64'(m_stall));
    @(posedge clk);
    if (flush_i) begin
      m_valid = 1'b0;
      q.delete();
    end else if (inst_valid_i && rdy) begin
      q.push_back(e);
      m_valid = 1'b1;
    end else if (ex_ready_i) begin
      m_valid = 1'b0;
    end
    if (inst_valid_i && hz && !flush_i && m_stall < 65535)
      m_stall++;
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && ex_valid_o) begin
      if (q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL bundle: ex_valid_o=1 got pc %0h expected none", pc_o);
      end else begin
        mon_a.aluop  = aluop_o;
        mon_a.alusel = alusel_o;
        mon_a.r1     = reg1_o;
        mon_a.r2     = reg2_o;
        mon_a.wd     = wd_o;
        mon_a.wreg   = wreg_o;
        mon_a.pc     = pc_o;
        mon_a.inv    = inst_invalid_o;
        n_chk++;
        if (mon_a !== q[0]) begin
          n_err++;
          $display("FAIL bundle: got %h expected %h", mon_a, q[0]);
        end
        if (ex_ready_i) void'(q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int s0;

  initial begin
    rst = 1'b1;
    inst_valid_i = 1'b1;
    inst_i = 32'h3401_1100;
    pc_i = 32'h0;
    ex_wreg_i = 1'b0;
    ex_wd_i = '0;
    ex_wdata_i = '0;
    ex_is_load_i = 1'b0;
    mem_wreg_i = 1'b0;
    mem_wd_i = '0;
    mem_wdata_i = '0;
    flush_i = 1'b0;
    ex_ready_i = 1'b1;
    m_valid = 1'b0;
    m_stall = 0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'hBAD0_BAD0;
    #12;
    chk("rst ex_valid", 64'(ex_valid_o), 64'd0);
    chk("rst aluop", 64'(aluop_o), 64'(NOP));
    chk("rst alusel", 64'(alusel_o), 64'd0);
    chk("rst reg1", 64'(reg1_o), 64'd0);
    chk("rst reg2", 64'(reg2_o), 64'd0);
    chk("rst wd", 64'(wd_o), 64'd0);
    chk("rst wreg", 64'(wreg_o), 64'd0);
    chk("rst pc", 64'(pc_o), 64'd0);
    chk("rst inv", 64'(inst_invalid_o), 64'd0);
    chk("rst stall", 64'(stall_cnt_o), 64'd0);
    chk("rst ready", 64'(inst_ready_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ORI $1,$0,0x1100
    pc_i = 32'h100;
    tick();
    chk("ori valid", 64'(ex_valid_o), 64'd1);
    chk("ori reg1", 64'(reg1_o), 64'd0);
    chk("ori reg2", 64'(reg2_o), 64'h1100);
    chk("ori wd", 64'(wd_o), 64'd1);
    chk("ori wreg", 64'(wreg_o), 64'd1);
    inst_valid_i = 1'b0;
    tick();

    // OR $3,$1,$2 with both writers targeting $1
    inst_valid_i = 1'b1;
    inst_i = 32'h0022_1825;
    pc_i = 32'h104;
    ex_wreg_i = 1'b1;
    ex_wd_i = 5'd1;
    ex_wdata_i = 32'h0000_1100;
    mem_wreg_i = 1'b1;
    mem_wd_i = 5'd1;
    mem_wdata_i = 32'h0000_DEAD;
    s0 = m_stall;
    tick();
`ifdef ID_FWD_EN
    chk("fwd reg1", 64'(reg1_o), 64'h1100);
`else
    chk("nofwd stall", 64'(stall_cnt_o), 64'(s0 + 1));
`endif
    inst_valid_i = 1'b0;
    ex_wreg_i = 1'b0;
    mem_wreg_i = 1'b0;
    tick();

    // load-use held two cycles
    inst_valid_i = 1'b1;
    pc_i = 32'h108;
    ex_wreg_i = 1'b1;
    ex_is_load_i = 1'b1;
    ex_wd_i = 5'd1;
    s0 = m_stall;
    tick();
    tick();
    chk("load-use stall", 64'(stall_cnt_o), 64'(s0 + 2));
    ex_is_load_i = 1'b0;
    ex_wreg_i = 1'b0;
    tick();
    inst_valid_i = 1'b0;
    tick();

    // backpressure three cycles
    inst_valid_i = 1'b1;
    inst_i = 32'h3422_00F0;
    pc_i = 32'h10C;
    tick();
    inst_i = 32'h3843_0F0F;
    pc_i = 32'h110;
    ex_ready_i = 1'b0;
    repeat (3) tick();
    chk("bp pc held", 64'(pc_o), 64'h10C);
    ex_ready_i = 1'b1;
    tick();
    chk("bp next pc", 64'(pc_o), 64'h110);
    inst_valid_i = 1'b0;
    tick();

    // asynchronous reset between edges
    inst_valid_i = 1'b1;
    inst_i = 32'h3401_1234;
    pc_i = 32'h114;
    tick();
    inst_valid_i = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("async rst valid", 64'(ex_valid_o), 64'd0);
    chk("async rst stall", 64'(stall_cnt_o), 64'd0);
    chk("async rst reg2", 64'(reg2_o), 64'd0);
    rst = 1'b0;
    q.delete();
    m_valid = 1'b0;
    m_stall = 0;
    tick();

    // flush overrides backpressure and acceptance
    inst_valid_i = 1'b1;
    pc_i = 32'h118;
    tick();
    ex_ready_i = 1'b0;
    flush_i = 1'b1;
    pc_i = 32'h11C;
    tick();
    chk("flush valid", 64'(ex_valid_o), 64'd0);
    flush_i = 1'b0;
    ex_ready_i = 1'b1;
    inst_valid_i = 1'b0;
    tick();

    // invalid opcode
    inst_valid_i = 1'b1;
    inst_i = 32'hFC00_0000;
    pc_i = 32'h120;
    tick();
    chk("inv flag", 64'(inst_invalid_o), 64'd1);
    chk("inv wreg", 64'(wreg_o), 64'd0);
    chk("inv aluop", 64'(aluop_o), 64'(NOP));
    inst_valid_i = 1'b0;
    tick();

    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0)
        for (int i = 1; i < 32; i++) regs[i] = $urandom;
      inst_valid_i = ($urandom_range(0, 3) != 0);
      inst_i = gen();
      pc_i = $urandom;
      ex_wreg_i = 1'($urandom_range(0, 1));
      ex_wd_i = 5'($urandom_range(0, 4));
      ex_wdata_i = $urandom;
      ex_is_load_i = ($urandom_range(0, 3) == 0);
      mem_wreg_i = 1'($urandom_range(0, 1));
      mem_wd_i = 5'($urandom_range(0, 4));
      mem_wdata_i = $urandom;
      flush_i = ($urandom_range(0, 19) == 0);
      ex_ready_i = ($urandom_range(0, 3) != 0);
      tick();
    end

    inst_valid_i = 1'b0;
    flush_i = 1'b0;
    ex_ready_i = 1'b1;
    ex_wreg_i = 1'b0;
    mem_wreg_i = 1'b0;
    tick();
    tick();
    chk("scoreboard drained", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/id_reg_stage.md
ID_REG_STAGE -- requirements
Module: id_reg_stage

Interface
REQ-001 Parameter DATA_W, 32, operand/PC data width; SHALL be >= 32.
REQ-002 Parameter REG_ADDR_W, 5, register-address width.
REQ-003 Parameter CNT_W, 16, width of the hazard-stall counter.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high (`RstEnable).
REQ-006 inst_valid_i  in  1 / inst_i  in  32 / pc_i  in  DATA_W: instruction offered by IF.
REQ-007 inst_ready_o  out  1  instruction is accepted on an edge where inst_valid_i && inst_ready_o.
REQ-008 reg1_read_o, reg2_read_o  out  1 / reg1_addr_o, reg2_addr_o  out  REG_ADDR_W: register-file read requests.
REQ-009 reg1_data_i, reg2_data_i  in  DATA_W: register-file combinational read data.
REQ-010 ex_wreg_i  in  1 / ex_wd_i  in  REG_ADDR_W / ex_wdata_i  in  DATA_W / ex_is_load_i  in  1: EX-stage writer.
REQ-011 mem_wreg_i  in  1 / mem_wd_i  in  REG_ADDR_W / mem_wdata_i  in  DATA_W: MEM-stage writer.
REQ-012 flush_i  in  1  discards the registered bundle and any offered instruction.
REQ-013 ex_valid_o  out  1 / ex_ready_i  in  1: valid/ready handshake toward EX.
REQ-014 aluop_o  out  8 / alusel_o  out  3 / reg1_o, reg2_o  out  DATA_W / wd_o  out  REG_ADDR_W / wreg_o  out  1 / pc_o  out  DATA_W / inst_invalid_o  out  1: registered bundle.
REQ-015 stall_cnt_o  out  CNT_W  count of hazard-stall cycles.

Function
REQ-016 Decode SHALL support ORI/ANDI/XORI (zero-extended imm), LUI (imm<<16), and SPECIAL AND/OR/XOR/NOR/SLL/SRL/SRA, producing the matching `EXE_*_OP / `EXE_RES_LOGIC or `EXE_RES_SHIFT.
REQ-017 I-type: reg1_o = rs operand, reg2_o = imm, wd_o = rt; R-type: wd_o = rd; shifts: reg1_o = zero-extended sa, reg2_o = rt operand.
REQ-018 An unread operand SHALL be replaced by imm; register 0 SHALL always read as zero and never be forwarded or cause a hazard.
REQ-019 Operand source priority: EX writer, then MEM writer, then register file, matching on nonzero address with wreg set.
REQ-020 Load-use hazard: ex_is_load_i && ex_wreg_i && ex_wd_i equals a read source -> inst_ready_o=0 for that cycle.
REQ-021 inst_ready_o = !flush_i && !hazard && (!ex_valid_o || ex_ready_i).
REQ-022 Latency: accepted instruction appears on the bundle at the next edge (1 cycle); bundle SHALL hold stable while ex_valid_o && !ex_ready_i.
REQ-023 ex_valid_o clears on an edge where the bundle is consumed and no new instruction is accepted.
REQ-024 flush_i SHALL clear ex_valid_o at the next edge, overriding acceptance and backpressure.
REQ-025 Invalid opcode/funct: accepted, forwarded with inst_invalid_o=1, wreg_o=0, aluop_o=`EXE_NOP_OP.
REQ-026 stall_cnt_o SHALL increment each cycle inst_valid_i && hazard && !flush_i, saturating at all-ones.

Reset
REQ-027 While rst=1 (immediately, no clock): ex_valid_o=0, aluop_o=`EXE_NOP_OP, alusel_o=`EXE_RES_NOP, all data/address outputs=0, wreg_o=0, inst_invalid_o=0, stall_cnt_o=0.
REQ-028 Reset mid-stall or mid-backpressure SHALL drop the held bundle; no instruction is accepted while rst=1.

Configuration
REQ-029 Macro ID_FWD_EN defined: EX/MEM forwarding per REQ-019; hazard is load-use only (REQ-020).
REQ-030 ID_FWD_EN undefined: no forwarding; hazard = any EX or MEM writer (wreg set, nonzero) matching a read source; operands come from register file only.

Verification
REQ-031 ORI $1,$0,0x1100 (0x34011100), ex_ready_i=1 -> next edge ex_valid_o=1, reg1_o=0, reg2_o=0x00001100, wd_o=1, wreg_o=1.
REQ-032 OR $3,$1,$2 (0x00221825), EX writes $1=0x00001100, MEM writes $1=0x0000DEAD -> reg1_o=0x00001100 (ID_FWD_EN); undefined: inst_ready_o=0, stall_cnt_o +1.
REQ-033 ex_is_load_i=1, ex_wd_i=1, inst reads $1, held 2 cycles -> inst_ready_o=0 both cycles, stall_cnt_o=2, then accepted when load clears.
REQ-034 ex_ready_i=0 for 3 cycles with ex_valid_o=1 -> bundle unchanged, inst_ready_o=0; ex_ready_i=1 -> next instruction on following edge.
REQ-035 rst pulsed between edges with ex_valid_o=1 -> ex_valid_o=0 and stall_cnt_o=0 before next clk edge; flush_i=1 -> ex_valid_o=0 next edge.
REQ-036 inst_i=0xFC000000 -> inst_invalid_o=1, wreg_o=0, aluop_o=`EXE_NOP_OP.
